// File: rtl/store_buffer_if.sv
// Store buffer port bundle: datapath store/load side, DM drain side and status.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
);
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             st_ready;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic [31:0]      ld_data;
  logic             drain_en;
  logic             dm_write;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_din;
  logic [PTR_W:0]   count;
  logic             empty;

  modport master (
    output st_valid, st_addr, st_data, ld_addr, drain_en,
    input  st_ready, ld_hit, ld_data, dm_write, dm_addr, dm_din, count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, drain_en,
    output st_ready, ld_hit, ld_data, dm_write, dm_addr, dm_din, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Word-granular FIFO write buffer in front of the data memory, with
// youngest-match store-to-load forwarding.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic not_empty, full, push, pop;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  assign not_empty = (count_q != '0);
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign push      = bus.st_valid && !full;
  assign pop       = bus.drain_en && not_empty;

  always_comb begin
    bus.st_ready = !full;
    bus.dm_write = pop;
    bus.empty    = !not_empty;
    bus.count    = count_q;
    bus.dm_addr  = '0;
    bus.dm_din   = '0;
    if (not_empty) begin
      bus.dm_addr = {addr_mem[rd_ptr_q], 2'b00};
      bus.dm_din  = data_mem[rd_ptr_q];
    end
  end

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    bus.ld_hit  = 1'b0;
    bus.ld_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (addr_mem[idx] == bus.ld_addr[31:2])) begin
        bus.ld_hit  = 1'b1;
        bus.ld_data = data_mem[idx];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.st_addr[31:2];
      data_mem[wr_ptr_q] <= bus.st_data;
    end
  end

endmodule
